tt_mux_scrambler: RTL
=====================

TT_MUX_SCRAMBLER -- requirements
Module: tt_mux_scrambler

Interface
REQ-001 SHALL expose exactly two ports: io_in (input, 8 bits) and io_out (output, 8 bits); all signals below are bit-fields of these.
REQ-002 io_in[0]  input  1  clk: the single clock; all state updates on its rising edge.
REQ-003 io_in[1]  input  1  rst_n: asynchronous, active-low reset.
REQ-004 io_in[2]  input  1  en: step enable; 0 = hold all state.
REQ-005 io_in[3]  input  1  mode: 0 = key from pin k, 1 = key from internal LFSR.
REQ-006 io_in[4]  input  1  a: data channel A, selected when sel=1.
REQ-007 io_in[5]  input  1  sel: channel select.
REQ-008 io_in[6]  input  1  b: data channel B, selected when sel=0.
REQ-009 io_in[7]  input  1  k: external key bit, used when mode=0.
REQ-010 io_out[7]  output  1  y: registered scrambled output bit.
REQ-011 io_out[6]  output  1  ks: current keystream bit, equal to lfsr[0] (register-driven, no input path).
REQ-012 io_out[5:0]  output  6  hist: y history; hist[0] newest; bits at or above HIST tie to 0.
REQ-013 Parameter LFSR_W, default 8, range 4..16: LFSR width.
REQ-014 Parameter TAPS, default 8'hB8, LFSR_W bits: Galois feedback mask.
REQ-015 Parameter SEED, default 8'h01, LFSR_W bits, nonzero: LFSR reset value.
REQ-016 Parameter HIST, default 6, range 1..6: history depth.

Function
REQ-017 Mux: m = sel ? a : b, combinational from the current inputs.
REQ-018 Key: key = mode ? lfsr[0] : k.
REQ-019 On a rising edge with en=1: y <= m XOR key; hist <= {hist[HIST-2:0], m XOR key}; for HIST=1, hist[0] <= m XOR key.
REQ-020 Latency SHALL be exactly 1 clock from input sample to y; hist[i] SHALL equal y delayed by i cycles, counted in enabled steps.
REQ-021 LFSR SHALL advance only on an edge with en=1 and mode=1.
REQ-022 LFSR advance rule: if lfsr[0]=1, lfsr <= (lfsr >> 1) XOR TAPS; otherwise lfsr <= lfsr >> 1.
REQ-023 The key bit used on an edge SHALL be the lfsr[0] value before that edge's advance.
REQ-024 With en=1 and mode=0: y and hist update; lfsr holds its value.
REQ-025 With en=0: y, hist and lfsr all hold, regardless of every other input.
REQ-026 A mode change SHALL take effect on the same edge it is sampled; there SHALL be no pipeline flush or bubble.
REQ-027 Lock-up guard: if lfsr ever equals 0, the next enabled mode=1 edge SHALL load SEED instead of shifting.
REQ-028 With the default TAPS/SEED, the LFSR sequence SHALL have period 255.
REQ-029 Parameter check: SEED=0, LFSR_W outside 4..16, or HIST outside 1..6 SHALL cause an elaboration error.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force y=0, hist=0 and lfsr=SEED, so io_out=8'h00 when SEED[0]=0 or io_out=8'h40 when SEED[0]=1.
REQ-031 Reset SHALL be released synchronously to the design; the first enabled edge after rst_n rises SHALL behave as a normal step.
REQ-032 Reset asserted mid-stream SHALL discard all history and keystream position, with no partial update.

Verification
REQ-033 Reset then mode=0, en=1, sel=1, a=1, k=0 for 1 edge -> y=1, hist=000001, ks=1, lfsr stays 8'h01.
REQ-034 Mode=1, a=0, sel=1, en=1 for 5 edges from reset -> y sequence 1,0,0,0,1; lfsr 8'hB8, 5C, 2E, 17, B3.
REQ-035 Same as REQ-034 with en=0 inserted after edge 2 for 3 cycles -> y, hist and lfsr frozen at 0, 000001 shifted state and 5C; sequence resumes unchanged.
REQ-036 Mode=1, en=1 for 255 edges from reset -> lfsr returns to 8'h01 and visits no zero state; mode=0 interleaved -> lfsr does not advance on those edges.
REQ-037 rst_n pulled low asynchronously between edges mid-run -> io_out=8'h40 immediately, with no clock edge required.
REQ-038 Mode=0, sel=0, b=1, k=1, en=1 -> y=0; then toggle k every edge -> y alternates 1,0,…, and hist shows the same pattern delayed by index.

Source files
------------

// File: rtl/tt_mux_scrambler.sv
// -----------------------------------------------------------------------------
// tt_mux_scrambler
//
// Purpose:
//   This block selects one bit from two data channels and XORs it with a key
//   bit. The key comes either from an external pin or from an internal Galois
//   LFSR. The result is registered as y. A short history of y is also kept,
//   shifted once per enabled step.
//
// Ports (everything is packed into two 8-bit buses):
//   io_in[0]   clk    rising-edge clock
//   io_in[1]   rst_n  asynchronous active-low reset
//   io_in[2]   en     step enable (0 = hold all state)
//   io_in[3]   mode   0 = key from pin k, 1 = key from LFSR
//   io_in[4]   a      data channel A (sel = 1)
//   io_in[5]   sel    channel select
//   io_in[6]   b      data channel B (sel = 0)
//   io_in[7]   k      external key bit
//   io_out[7]  y      registered scrambled bit
//   io_out[6]  ks     current keystream bit (lfsr[0])
//   io_out[5:0] hist  y history, hist[0] newest; bits >= HIST read 0
// -----------------------------------------------------------------------------
module tt_mux_scrambler #(
    parameter int                LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(8'hB8),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(8'h01),
    parameter int                HIST   = 6
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // Reject configurations that cannot work, at elaboration time.
    if (LFSR_W < 4 || LFSR_W > 16) begin : g_bad_lfsr_w
        $error("tt_mux_scrambler: LFSR_W must be within 4..16");
    end
    if (HIST < 1 || HIST > 6) begin : g_bad_hist
        $error("tt_mux_scrambler: HIST must be within 1..6");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("tt_mux_scrambler: SEED must be nonzero");
    end

    // Advance the LFSR by one step. The all-zero state is a lock-up state, so
    // it reloads SEED instead of shifting.
    function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] cur);
        logic [LFSR_W-1:0] nxt;
        if (cur == '0) begin
            nxt = SEED;
        end else if (cur[0]) begin
            nxt = (cur >> 1) ^ TAPS;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    // Split the packed input bus into named signals.
    logic clk_s;
    logic rst_n_s;
    logic en_s;
    logic mode_s;
    logic a_s;
    logic sel_s;
    logic b_s;
    logic k_s;

    assign clk_s   = io_in[0];
    assign rst_n_s = io_in[1];
    assign en_s    = io_in[2];
    assign mode_s  = io_in[3];
    assign a_s     = io_in[4];
    assign sel_s   = io_in[5];
    assign b_s     = io_in[6];
    assign k_s     = io_in[7];

    logic              y_r;
    logic [LFSR_W-1:0] lfsr_r;
    logic [HIST-1:0]   hist_r;
    logic [5:0]        hist_pad_s;
    logic              mux_s;
    logic              key_s;
    logic              y_next_s;

    // Channel mux and key select. Both are combinational from the current pins,
    // so a mode change affects the same edge on which it is sampled.
    always_comb begin
        mux_s = 1'b0;
        key_s = 1'b0;
        if (sel_s) begin
            mux_s = a_s;
        end else begin
            mux_s = b_s;
        end
        if (mode_s) begin
            key_s = lfsr_r[0];
        end else begin
            key_s = k_s;
        end
        y_next_s = mux_s ^ key_s;
    end

    // Output bit and keystream register. The key uses lfsr[0] from before
    // this edge's advance.
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            y_r    <= 1'b0;
            lfsr_r <= SEED;
        end else if (en_s) begin
            y_r <= y_next_s;
            if (mode_s) begin
                lfsr_r <= lfsr_next_f(lfsr_r);
            end else begin
                lfsr_r <= lfsr_r;
            end
        end else begin
            y_r    <= y_r;
            lfsr_r <= lfsr_r;
        end
    end

    if (HIST == 1) begin : g_hist_one
        // A single-entry history simply mirrors the newest y.
        always_ff @(posedge clk_s or negedge rst_n_s) begin
            if (!rst_n_s) begin
                hist_r <= '0;
            end else if (en_s) begin
                hist_r <= y_next_s;
            end else begin
                hist_r <= hist_r;
            end
        end
    end else begin : g_hist_many
        // The history shift register: the newest bit enters at index 0.
        always_ff @(posedge clk_s or negedge rst_n_s) begin
            if (!rst_n_s) begin
                hist_r <= '0;
            end else if (en_s) begin
                hist_r <= {hist_r[HIST-2:0], y_next_s};
            end else begin
                hist_r <= hist_r;
            end
        end
    end

    // Zero-extend the history to the 6-bit output field.
    always_comb begin
        hist_pad_s           = 6'b000000;
        hist_pad_s[HIST-1:0] = hist_r;
    end

    assign io_out = {y_r, lfsr_r[0], hist_pad_s};

endmodule
